fetch: RTL and testbench

Instruction fetch stage: owns the program counter, issues word reads on the instruction-memory request/acknowledge interface and presents one registered instruction per cycle to the decode stage through the pipeline-in bundle (PC, instruction, exception, valid). It honours decode-side stall and redirects from execute, and raises fetch-side exceptions (misaligned target, access fault) that decode passes through unchanged. It sits between instruction memory and decode.

---
 rtl/fetch_if.sv | 25 ++
 rtl/fetch.sv | 112 +++++++++++
 tb/tb_fetch.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/acknowledge bus between fetch and memory.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 3
`endif
`ifndef EX_INSTR_MISALIGNED
`define EX_INSTR_MISALIGNED 4'd0
`endif
`ifndef EX_INSTR_ACCESS_FAULT
`define EX_INSTR_ACCESS_FAULT 4'd1
`endif
interface fetch_if;
  logic imem_req;
  logic [`ADDR_SIZE:0] imem_addr;
  logic imem_ack;
  logic [`INSTR_SIZE:0] imem_rdata;
  logic imem_err;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata, imem_err);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata, imem_err);
endinterface

// File: rtl/fetch.sv
// fetch: PC owner, issues instruction-memory reads and presents one registered bundle per cycle to decode.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 3
`endif
`ifndef EX_INSTR_MISALIGNED
`define EX_INSTR_MISALIGNED 4'd0
`endif
`ifndef EX_INSTR_ACCESS_FAULT
`define EX_INSTR_ACCESS_FAULT 4'd1
`endif
module fetch #(
  parameter logic [`ADDR_SIZE:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_if.master               imem,
  output logic [`ADDR_SIZE:0]   PC_out,
  output logic [`INSTR_SIZE:0]  instr_out,
  output logic [`EX_WIDTH:0]    exception_out,
  output logic                  exception_out_valid,
  output logic                  pipeline_out_valid,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [`ADDR_SIZE:0]   redirect_pc
);
  localparam logic [`INSTR_SIZE:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, WAIT} state_t;
  state_t state, state_n;
  logic [`ADDR_SIZE:0] pc, pc_n, drain_addr, drain_n, po_n;
  logic [`INSTR_SIZE:0] buf_instr, bi_n, io_n;
  logic [`EX_WIDTH:0] eo_n;
  logic buf_err, be_n, ev_n, vo_n;
  logic misal, req, ack, fault, exc, take;
  assign misal = pc[1:0] != 2'b00;
  assign req = reset & ((state == FETCH & !misal) | state == DRAIN);
  assign imem.imem_req = req;
  assign imem.imem_addr = state == DRAIN ? drain_addr : pc;
  assign ack = req & imem.imem_ack;
  assign fault = state == HOLD ? buf_err : imem.imem_err & !misal;
  assign exc = fault | (state == FETCH & misal);
  assign take = !stall & (state == HOLD | (state == FETCH & (ack | misal)));
  // drain_addr keeps the abandoned address on the bus until its response is swallowed
  always_comb begin
    state_n = state;
    pc_n = pc;
    drain_n = drain_addr;
    bi_n = buf_instr;
    be_n = buf_err;
    po_n = PC_out;
    io_n = instr_out;
    eo_n = exception_out;
    ev_n = exception_out_valid;
    vo_n = pipeline_out_valid;
    if (state == DRAIN & ack) state_n = FETCH;
    if (redirect_valid) begin
      pc_n = redirect_pc;
      vo_n = 1'b0;
      ev_n = 1'b0;
      eo_n = '0;
      be_n = 1'b0;
      state_n = req & !imem.imem_ack ? DRAIN : FETCH;
      drain_n = state == DRAIN ? drain_addr : pc;
    end else if (take) begin
      po_n = pc;
      vo_n = 1'b1;
      ev_n = exc;
      io_n = exc ? NOP : state == HOLD ? buf_instr : imem.imem_rdata;
      eo_n = !exc ? '0 : fault ? `EX_INSTR_ACCESS_FAULT : `EX_INSTR_MISALIGNED;
      pc_n = exc ? pc : pc + 32'd4;
      state_n = exc ? WAIT : FETCH;
    end else if (state == FETCH & stall & ack) begin
      bi_n = imem.imem_rdata;
      be_n = imem.imem_err;
      state_n = HOLD;
    end else if (!stall) begin
      vo_n = 1'b0;
      ev_n = 1'b0;
      eo_n = '0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      drain_addr <= RESET_PC;
      buf_instr <= '0;
      buf_err <= 1'b0;
      PC_out <= '0;
      instr_out <= '0;
      exception_out <= '0;
      exception_out_valid <= 1'b0;
      pipeline_out_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      drain_addr <= drain_n;
      buf_instr <= bi_n;
      buf_err <= be_n;
      PC_out <= po_n;
      instr_out <= io_n;
      exception_out <= eo_n;
      exception_out_valid <= ev_n;
      pipeline_out_valid <= vo_n;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for fetch with a configurable-latency instruction memory model.
module tb_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [3:0] MIS = 4'd0;
  localparam logic [3:0] AF = 4'd1;
  typedef struct packed {logic [31:0] pc; logic [31:0] ins; logic exv; logic [3:0] ex;} bnd_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] PC_out, instr_out;
  logic [3:0] exception_out;
  logic exception_out_valid, pipeline_out_valid;
  int checks = 0;
  int failures = 0;
  int wait_cyc = 0;
  int cnt = 0;
  logic [31:0] err_addr = 32'h1;
  bnd_t q[$];
  bnd_t e;
  fetch_if bus();
  fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem(bus),
    .PC_out(PC_out), .instr_out(instr_out), .exception_out(exception_out),
    .exception_out_valid(exception_out_valid), .pipeline_out_valid(pipeline_out_valid),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction
  // ack arrives after wait_cyc wait states of a continuously held request
  assign bus.imem_ack = bus.imem_req && cnt == wait_cyc;
  assign bus.imem_rdata = mem(bus.imem_addr);
  assign bus.imem_err = bus.imem_ack && bus.imem_addr == err_addr;
  always @(posedge clk) cnt <= (bus.imem_req && !bus.imem_ack) ? cnt + 1 : 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic x, input logic [3:0] c);
    q.push_back(bnd_t'({p, i, x, c}));
  endtask
  always @(negedge clk) if (reset && pipeline_out_valid && !stall) begin
    if (q.size() == 0) chk("extra_bundle", 32'(q.size()), 32'd1);
    else begin
      e = q.pop_front();
      chk("sb_pc", PC_out, e.pc);
      chk("sb_instr", instr_out, e.ins);
      chk("sb_exv", {31'd0, exception_out_valid}, {31'd0, e.exv});
      chk("sb_ex", {28'd0, exception_out}, {28'd0, e.ex});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic restart(input int w, input logic [31:0] ea);
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    wait_cyc = w;
    err_addr = ea;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask
  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc = a;
    step();
    redirect_valid = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_ex", {28'd0, exception_out}, 32'd0);
    chk("rst_exv", {31'd0, exception_out_valid}, 32'd0);
    chk("rst_valid", {31'd0, pipeline_out_valid}, 32'd0);
    restart(0, 32'h1);
    chk("boot_req", {31'd0, bus.imem_req}, 32'd1);
    chk("boot_addr", bus.imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) push(32'(i * 4), mem(32'(i * 4)), 1'b0, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("zw_valid", {31'd0, pipeline_out_valid}, 32'd1);
      chk("zw_pc", PC_out, 32'((i - 1) * 4));
    end
    step();
    chk("zw_left", 32'(q.size()), 32'd0);
    restart(2, 32'h1);
    push(32'h0, mem(32'h0), 1'b0, 4'd0);
    push(32'h4, mem(32'h4), 1'b0, 4'd0);
    push(32'h8, mem(32'h8), 1'b0, 4'd0);
    step(); step(); step();
    chk("lat_pc0", PC_out, 32'h0);
    chk("lat_addr", bus.imem_addr, 32'h4);
    step();
    chk("lat_bubble1", {31'd0, pipeline_out_valid}, 32'd0);
    chk("lat_req", {31'd0, bus.imem_req}, 32'd1);
    chk("lat_addr", bus.imem_addr, 32'h4);
    step();
    chk("lat_bubble2", {31'd0, pipeline_out_valid}, 32'd0);
    chk("lat_addr", bus.imem_addr, 32'h4);
    step();
    chk("lat_pc4", PC_out, 32'h4);
    chk("lat_valid4", {31'd0, pipeline_out_valid}, 32'd1);
    stall = 1'b1;
    step();
    chk("stall_pc", PC_out, 32'h4);
    step();
    chk("stall_valid", {31'd0, pipeline_out_valid}, 32'd1);
    step();
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_pc", PC_out, 32'h4);
    stall = 1'b0;
    step();
    chk("unstall_pc8", PC_out, 32'h8);
    step(); step();
    chk("mid_req", {31'd0, bus.imem_req}, 32'd1);
    chk("mid_addr", bus.imem_addr, 32'hC);
    reset = 1'b0;
    #1;
    chk("rst_abort_req", {31'd0, bus.imem_req}, 32'd0);
    chk("lat_left", 32'(q.size()), 32'd0);
    restart(2, 32'h1);
    redirect(32'h20);
    chk("drain_addr0", bus.imem_addr, 32'h0);
    step(); step();
    chk("rd_addr20", bus.imem_addr, 32'h20);
    redirect(32'h100);
    chk("drain_req", {31'd0, bus.imem_req}, 32'd1);
    chk("drain_addr20", bus.imem_addr, 32'h20);
    step();
    chk("drain_addr20b", bus.imem_addr, 32'h20);
    step();
    chk("rd_addr100", bus.imem_addr, 32'h100);
    chk("rd_bubble", {31'd0, pipeline_out_valid}, 32'd0);
    push(32'h100, mem(32'h100), 1'b0, 4'd0);
    step(); step(); step();
    chk("rd_pc100", PC_out, 32'h100);
    step();
    chk("rd_left", 32'(q.size()), 32'd0);
    restart(0, 32'h1);
    redirect(32'h102);
    chk("mis_noreq", {31'd0, bus.imem_req}, 32'd0);
    push(32'h102, NOP, 1'b1, MIS);
    step();
    chk("mis_exv", {31'd0, exception_out_valid}, 32'd1);
    chk("mis_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    chk("mis_drop", {31'd0, pipeline_out_valid}, 32'd0);
    step();
    chk("mis_idle", {31'd0, bus.imem_req}, 32'd0);
    redirect(32'h200);
    chk("mis_resume", bus.imem_addr, 32'h200);
    chk("mis_resume_req", {31'd0, bus.imem_req}, 32'd1);
    push(32'h200, mem(32'h200), 1'b0, 4'd0);
    step(); step();
    chk("mis_left", 32'(q.size()), 32'd0);
    restart(0, 32'h1);
    redirect(32'hFFFF_FFFC);
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b0, 4'd0);
    push(32'h0, mem(32'h0), 1'b0, 4'd0);
    step(); step();
    chk("wrap_pc0", PC_out, 32'h0);
    step();
    chk("wrap_left", 32'(q.size()), 32'd0);
    restart(0, 32'h40);
    redirect(32'h40);
    push(32'h40, NOP, 1'b1, AF);
    step();
    chk("af_req", {31'd0, bus.imem_req}, 32'd0);
    step(); step();
    chk("af_idle", {31'd0, bus.imem_req}, 32'd0);
    redirect(32'h0);
    chk("af_resume", {31'd0, bus.imem_req}, 32'd1);
    push(32'h0, mem(32'h0), 1'b0, 4'd0);
    step(); step();
    chk("af_left", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
